// File: rtl/pingpong_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_ctrl
//
// Write-side controller for a two-bank (A/B) ping-pong packet buffer. Bytes
// from a strobed source are steered into whichever bank is free. A bank that
// holds a complete packet of PACKAGE_SIZE bytes is handed to the read side
// through send_req_x. The read side reports that a bank has drained with the
// asynchronous level rd_done_x. The controller synchronises that level,
// releases the bank and acknowledges with a one-cycle rd_clr_x pulse.
//
// Bank lifecycle   : FREE -> FILLING -> SENDING -> FREE
//                    (an aborted fill goes FILLING -> FREE)
// Controller FSM   : IDLE, FILL_A, FILL_B, DROP
//
// Optional feature : define PPCTRL_STATS_EN to build the saturating drop and
//                    abort statistics counters. Without it, drop_cnt and
//                    abort_cnt are tied to 0.
// Assumes PACKAGE_SIZE >= 2 and CNT_WIDTH >= clog2(PACKAGE_SIZE).
//
// Ports
//   wr_clk, rst_n        write clock; asynchronous active-low reset
//   din_valid, din       source byte strobe and byte
//   rd_done_a/b          bank-drained level from the read domain (async)
//   ram_din              registered byte, shared by both banks
//   wr_en_a/b            bank write enables, held high for a whole fill
//   send_req_a/b         bank full and ready to transmit (level)
//   rd_clr_a/b           one-cycle pulse clearing the read side's drained flag
//   fill_cnt             index of the byte being written into the current bank
//   drop_cnt, abort_cnt  saturating statistics counters
// -----------------------------------------------------------------------------
module pingpong_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int PACKAGE_SIZE = 11552,
  parameter int CNT_WIDTH    = 14
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_done_a,
  input  logic                  rd_done_b,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic                  send_req_a,
  output logic                  send_req_b,
  output logic                  rd_clr_a,
  output logic                  rd_clr_b,
  output logic [CNT_WIDTH-1:0]  fill_cnt,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           abort_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL_A = 2'd1;
  localparam logic [1:0] ST_FILL_B = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  localparam logic [1:0] BK_FREE    = 2'd0;
  localparam logic [1:0] BK_FILLING = 2'd1;
  localparam logic [1:0] BK_SENDING = 2'd2;

  // A byte accepted while fill_cnt sits here is the last byte of the packet.
  localparam logic [CNT_WIDTH-1:0] PRE_LAST_IDX = CNT_WIDTH'(PACKAGE_SIZE - 2);

  logic [1:0]            state_q, state_d;
  logic [1:0]            bank_a_q, bank_a_d, bank_b_q, bank_b_d;
  logic                  pref_b_q, pref_b_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  wr_en_a_q, wr_en_a_d, wr_en_b_q, wr_en_b_d;
  logic                  send_req_a_q, send_req_a_d, send_req_b_q, send_req_b_d;
  logic                  rd_clr_a_q, rd_clr_a_d, rd_clr_b_q, rd_clr_b_d;
  logic [CNT_WIDTH-1:0]  fill_cnt_q, fill_cnt_d;

  // Per-bank pipeline: [0] metastable stage, [1] synchronised level,
  // [2] previous synchronised level, used for rising-edge detection.
  logic [2:0] done_a_pipe_q, done_b_pipe_q;
  logic       done_a_rise, done_b_rise;
  logic       free_a, free_b;
  logic       a_free, b_free, start_a, start_b;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_a_pipe_q <= '0;
      done_b_pipe_q <= '0;
    end else begin
      done_a_pipe_q <= {done_a_pipe_q[1:0], rd_done_a};
      done_b_pipe_q <= {done_b_pipe_q[1:0], rd_done_b};
    end
  end

  assign done_a_rise = done_a_pipe_q[1] & ~done_a_pipe_q[2];
  assign done_b_rise = done_b_pipe_q[1] & ~done_b_pipe_q[2];

  // A drained report only counts for a bank that was actually handed over.
  assign free_a = done_a_rise && (bank_a_q == BK_SENDING);
  assign free_b = done_b_rise && (bank_b_q == BK_SENDING);

  // Bank selection works on the registered bank states, so a bank that frees
  // in this same cycle is not yet a candidate.
  assign a_free  = (bank_a_q == BK_FREE);
  assign b_free  = (bank_b_q == BK_FREE);
  assign start_a = pref_b_q ? (!b_free && a_free) : a_free;
  assign start_b = pref_b_q ? b_free : (!a_free && b_free);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    bank_a_d   = bank_a_q;
    bank_b_d   = bank_b_q;
    pref_b_d   = pref_b_q;
    ram_din_d  = ram_din_q;
    wr_en_a_d  = 1'b0;
    wr_en_b_d  = 1'b0;
    fill_cnt_d = fill_cnt_q;

    // Release drained banks. send_req drops in the same cycle as rd_clr pulses.
    if (free_a) bank_a_d = BK_FREE;
    if (free_b) bank_b_d = BK_FREE;
    rd_clr_a_d   = free_a;
    rd_clr_b_d   = free_b;
    send_req_a_d = (bank_a_q == BK_SENDING) && !free_a;
    send_req_b_d = (bank_b_q == BK_SENDING) && !free_b;

    case (state_q)
      ST_IDLE: begin
        fill_cnt_d = '0;
        if (din_valid) begin
          if (start_a) begin
            bank_a_d  = BK_FILLING;
            wr_en_a_d = 1'b1;
            ram_din_d = din;
            state_d   = ST_FILL_A;
          end else if (start_b) begin
            bank_b_d  = BK_FILLING;
            wr_en_b_d = 1'b1;
            ram_din_d = din;
            state_d   = ST_FILL_B;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_FILL_A, ST_FILL_B: begin
        if (din_valid) begin
          // The enable stays high across the whole fill; the bank restarts
          // its write address whenever it drops.
          ram_din_d  = din;
          fill_cnt_d = fill_cnt_q + CNT_WIDTH'(1);
          wr_en_a_d  = (state_q == ST_FILL_A);
          wr_en_b_d  = (state_q == ST_FILL_B);
          if (fill_cnt_q == PRE_LAST_IDX) begin
            // Last byte accepted. The enable still covers its write cycle.
            // Going back to IDLE now lets the next byte start the other
            // bank without a bubble.
            if (state_q == ST_FILL_A) bank_a_d = BK_SENDING;
            else                      bank_b_d = BK_SENDING;
            pref_b_d = (state_q == ST_FILL_A);
            state_d  = ST_IDLE;
          end
        end else begin
          // The source stopped short of a full packet, so the partial data
          // is discarded.
          if (state_q == ST_FILL_A) bank_a_d = BK_FREE;
          else                      bank_b_d = BK_FREE;
          fill_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end

      ST_DROP: begin
        // Bytes are discarded until the burst ends, even if a bank frees
        // partway through it.
        if (!din_valid) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bank_a_q     <= BK_FREE;
      bank_b_q     <= BK_FREE;
      pref_b_q     <= 1'b0;
      ram_din_q    <= '0;
      wr_en_a_q    <= 1'b0;
      wr_en_b_q    <= 1'b0;
      send_req_a_q <= 1'b0;
      send_req_b_q <= 1'b0;
      rd_clr_a_q   <= 1'b0;
      rd_clr_b_q   <= 1'b0;
      fill_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before the edge, regardless of statement order.
      state_q      <= state_d;
      bank_a_q     <= bank_a_d;
      bank_b_q     <= bank_b_d;
      pref_b_q     <= pref_b_d;
      ram_din_q    <= ram_din_d;
      wr_en_a_q    <= wr_en_a_d;
      wr_en_b_q    <= wr_en_b_d;
      send_req_a_q <= send_req_a_d;
      send_req_b_q <= send_req_b_d;
      rd_clr_a_q   <= rd_clr_a_d;
      rd_clr_b_q   <= rd_clr_b_d;
      fill_cnt_q   <= fill_cnt_d;
    end
  end

  assign ram_din    = ram_din_q;
  assign wr_en_a    = wr_en_a_q;
  assign wr_en_b    = wr_en_b_q;
  assign send_req_a = send_req_a_q;
  assign send_req_b = send_req_b_q;
  assign rd_clr_a   = rd_clr_a_q;
  assign rd_clr_b   = rd_clr_b_q;
  assign fill_cnt   = fill_cnt_q;

`ifdef PPCTRL_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d, abort_cnt_q, abort_cnt_d;
  logic        drop_evt, abort_evt;

  // A dropped byte is either the one that finds no free bank in IDLE or any
  // byte arriving while in DROP. A fill state never sees a completed packet
  // with din_valid low, so din_valid low there is always an abort.
  assign drop_evt  = din_valid &&
                     ((state_q == ST_DROP) ||
                      ((state_q == ST_IDLE) && !(start_a || start_b)));
  assign abort_evt = !din_valid &&
                     ((state_q == ST_FILL_A) || (state_q == ST_FILL_B));

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (drop_evt && (drop_cnt_q != 16'hFFFF))   drop_cnt_d  = drop_cnt_q + 16'd1;
    if (abort_evt && (abort_cnt_q != 16'hFFFF)) abort_cnt_d = abort_cnt_q + 16'd1;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign abort_cnt = abort_cnt_q;
`else
  assign drop_cnt  = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the byte width written to each bank.
REQ-002 SHALL have parameter PACKAGE_SIZE, default 11552, meaning the bytes per packet and per bank fill.
REQ-003 SHALL have parameter CNT_WIDTH, default 14, meaning the width of the fill counter; CNT_WIDTH >= clog2(PACKAGE_SIZE).
REQ-004 SHALL have port wr_clk  in  1  write clock; all logic in this domain.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port din_valid  in  1  source byte strobe.
REQ-007 SHALL have port din  in  DATA_WIDTH  source byte.
REQ-008 SHALL have ports rd_done_a and rd_done_b  in  1 each  bank-drained level from the read domain (asynchronous).
REQ-009 SHALL have port ram_din  out  DATA_WIDTH  registered byte to both banks.
REQ-010 SHALL have ports wr_en_a and wr_en_b  out  1 each  bank write enables.
REQ-011 SHALL have ports send_req_a and send_req_b  out  1 each  bank-full, ready-to-transmit level.
REQ-012 SHALL have ports rd_clr_a and rd_clr_b  out  1 each  one-cycle pulse clearing the bank's drained flag.
REQ-013 SHALL have port fill_cnt  out  CNT_WIDTH  bytes written into the current bank.
REQ-014 SHALL have ports drop_cnt and abort_cnt  out  16 each  statistics counters.

Function
REQ-015 SHALL track each bank as FREE, FILLING or SENDING; the controller FSM SHALL have states IDLE, FILL_A, FILL_B and DROP.
REQ-016 SHALL, in IDLE with din_valid=1, select the bank opposite the last completed bank if FREE, else the other bank if FREE, else enter DROP; after reset the preferred bank SHALL be A.
REQ-017 SHALL register din into ram_din and assert the selected wr_en_x one cycle after the sampled din_valid, one byte per cycle.
REQ-018 SHALL hold wr_en_x continuously for a bank fill, because the bank restarts its write address at 0 whenever its enable drops.
REQ-019 SHALL, when the PACKAGE_SIZE-th byte is written, mark the bank SENDING, assert send_req_x on the next cycle, return to IDLE and make the opposite bank preferred.
REQ-020 SHALL treat din_valid=0 while FILL_x with fill_cnt<PACKAGE_SIZE as an abort: the partial data is discarded, the bank returns to FREE, abort_cnt increments, and the FSM returns to IDLE.
REQ-021 SHALL allow a byte arriving in the cycle after completion to start a fill of the other bank without a bubble if that bank is FREE.
REQ-022 SHALL, in DROP, discard bytes with drop_cnt +1 per byte until din_valid=0, then return to IDLE; a bank freeing mid-burst SHALL NOT be entered.
REQ-023 SHALL synchronise rd_done_x through 2 flops; a synchronised rising edge while SENDING SHALL set the bank FREE, deassert send_req_x and pulse rd_clr_x for exactly one cycle.
REQ-024 SHALL ignore a rd_done_x edge while the bank is not SENDING.
REQ-025 SHALL, when bank x frees in the same cycle the FSM is in IDLE with din_valid=1 and the other bank is busy, evaluate selection on the pre-update state (enter DROP).
REQ-026 SHALL saturate drop_cnt and abort_cnt at 16'hFFFF.
REQ-027 SHALL make fill_cnt count 0..PACKAGE_SIZE-1 within a fill and clear it to 0 on completion or abort.

Reset
REQ-028 SHALL, on rst_n=0, immediately force FSM IDLE, both banks FREE, preferred bank A, all wr_en_x, send_req_x and rd_clr_x to 0, ram_din, fill_cnt, drop_cnt, abort_cnt and the synchronisers to 0.
REQ-029 SHALL, on reset during a fill, deassert wr_en_x and not pulse rd_clr_x or increment any counter.

Configuration
REQ-030 SHALL, with PPCTRL_STATS_EN defined, implement drop_cnt and abort_cnt as specified.
REQ-031 SHALL, without PPCTRL_STATS_EN, tie drop_cnt and abort_cnt to 0 and compile no counter logic, with all other behaviour unchanged.

Verification (PACKAGE_SIZE=16, PPCTRL_STATS_EN defined)
REQ-032 SHALL cover: 16-byte contiguous burst 0x00..0x0F -> wr_en_a high for 16 cycles starting 1 cycle after the first strobe, ram_din 0x00..0x0F, send_req_a=1 on the following cycle.
REQ-033 SHALL cover: a 32-byte burst -> A fills with bytes 0-15, then B fills with bytes 16-31 with no gap cycle; send_req_a and send_req_b are both 1.
REQ-034 SHALL cover: both banks SENDING plus an 8-byte burst -> no wr_en asserted and drop_cnt=8.
REQ-035 SHALL cover: din_valid dropped after 5 bytes in bank A -> abort_cnt=1, bank A FREE, and the next burst fills A with fill_cnt restarting at 0.
REQ-036 SHALL cover: rd_done_a rising while A is SENDING -> rd_clr_a pulses exactly 1 cycle, 2-3 wr_clk cycles later, and send_req_a falls in that same cycle.
REQ-037 SHALL cover: rst_n asserted mid-fill -> all outputs 0 immediately, and the next burst fills bank A.
